// File: rtl/riscv_pipe_ctrl.sv
// Pipeline valid/rd/we tracker with RAW issue interlock, global stall, partial flush and perf counters.
// Optional operand forwarding from RESULT_STAGE onward is enabled by defining RISCV_PIPE_FWD_EN.
module riscv_pipe_ctrl #(
   parameter int NUM_STAGES   = 10,
   parameter int RESULT_STAGE = 6,
   parameter int FLUSH_DEPTH  = 3,
   parameter int REG_AW       = 5,
   parameter int CNT_W        = 32,
   localparam int SW          = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  iss_valid,
   output logic                  iss_ready,
   input  logic [REG_AW-1:0]     iss_rd,
   input  logic                  iss_we,
   input  logic [REG_AW-1:0]     iss_rs1,
   input  logic [REG_AW-1:0]     iss_rs2,
   input  logic                  iss_rs1_used,
   input  logic                  iss_rs2_used,
   input  logic                  stall_in,
   input  logic                  flush_in,
   output logic [NUM_STAGES-1:0] stage_valid,
   output logic                  com_valid,
   output logic [REG_AW-1:0]     com_rd,
   output logic                  com_we,
   output logic                  fwd_rs1_hit,
   output logic                  fwd_rs2_hit,
   output logic [SW-1:0]         fwd_rs1_stage,
   output logic [SW-1:0]         fwd_rs2_stage,
   output logic [CNT_W-1:0]      perf_commit_cnt,
   output logic [CNT_W-1:0]      perf_stall_cnt
);

   if (NUM_STAGES < 2 || NUM_STAGES > 32) begin : g_bad_num_stages
      $error("riscv_pipe_ctrl: NUM_STAGES out of range");
   end
   if (RESULT_STAGE < 1 || RESULT_STAGE > NUM_STAGES - 1) begin : g_bad_result_stage
      $error("riscv_pipe_ctrl: RESULT_STAGE out of range");
   end
   if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > NUM_STAGES) begin : g_bad_flush_depth
      $error("riscv_pipe_ctrl: FLUSH_DEPTH out of range");
   end

   logic [NUM_STAGES-1:0] st_vld;
   logic [NUM_STAGES-1:0] st_we;
   logic [REG_AW-1:0]     st_rd [NUM_STAGES];
   logic [NUM_STAGES-1:0] kill;
   logic [NUM_STAGES-1:0] vld_nxt;
   logic                  fire;
   logic                  match1, match2;
   logic                  haz1, haz2;
   logic                  hit1, hit2;
`ifdef RISCV_PIPE_FWD_EN
   int                    idx1, idx2;
`endif

   // Scan oldest to youngest so the last match recorded is the youngest producer.
   always_comb begin
      match1 = 1'b0;
      match2 = 1'b0;
`ifdef RISCV_PIPE_FWD_EN
      idx1 = 0;
      idx2 = 0;
`endif
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
         if (st_vld[k] && st_we[k] && iss_rs1_used && (iss_rs1 != '0) && (st_rd[k] == iss_rs1)) begin
            match1 = 1'b1;
`ifdef RISCV_PIPE_FWD_EN
            idx1 = k;
`endif
         end
         if (st_vld[k] && st_we[k] && iss_rs2_used && (iss_rs2 != '0) && (st_rd[k] == iss_rs2)) begin
            match2 = 1'b1;
`ifdef RISCV_PIPE_FWD_EN
            idx2 = k;
`endif
         end
      end
`ifdef RISCV_PIPE_FWD_EN
      haz1 = match1 && (idx1 < RESULT_STAGE);
      haz2 = match2 && (idx2 < RESULT_STAGE);
      hit1 = match1 && (idx1 >= RESULT_STAGE);
      hit2 = match2 && (idx2 >= RESULT_STAGE);
`else
      haz1 = match1;
      haz2 = match2;
      hit1 = 1'b0;
      hit2 = 1'b0;
`endif
   end

`ifdef RISCV_PIPE_FWD_EN
   assign fwd_rs1_stage = hit1 ? SW'(idx1) : '0;
   assign fwd_rs2_stage = hit2 ? SW'(idx2) : '0;
`else
   assign fwd_rs1_stage = '0;
   assign fwd_rs2_stage = '0;
`endif
   assign fwd_rs1_hit = hit1;
   assign fwd_rs2_hit = hit2;

   assign iss_ready = !stall_in && !flush_in && !haz1 && !haz2;
   assign fire      = iss_valid && iss_ready;

   // Killed stages are dropped before the shift, so an old killed stage cannot advance into a survivor slot.
   always_comb begin
      kill = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         if (flush_in && (k < FLUSH_DEPTH)) kill[k] = 1'b1;
      end
      if (stall_in) vld_nxt = st_vld & ~kill;
      else          vld_nxt = {st_vld[NUM_STAGES-2:0] & ~kill[NUM_STAGES-2:0], fire};
   end

   // A flush deep enough to reach the last stage also suppresses its commit.
   assign com_valid   = st_vld[NUM_STAGES-1] && !stall_in && !kill[NUM_STAGES-1];
   assign com_rd      = st_rd[NUM_STAGES-1];
   assign com_we      = st_we[NUM_STAGES-1];
   assign stage_valid = st_vld;

   always_ff @(posedge clk) begin
      if (!rst_n) st_vld <= '0;
      else        st_vld <= vld_nxt;
   end

   always_ff @(posedge clk) begin
      if (!stall_in) begin
         st_rd[0] <= iss_rd;
         st_we[0] <= iss_we;
         for (int k = 1; k < NUM_STAGES; k++) begin
            st_rd[k] <= st_rd[k-1];
            st_we[k] <= st_we[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_commit_cnt <= '0;
         perf_stall_cnt  <= '0;
      end else begin
         if (com_valid)              perf_commit_cnt <= perf_commit_cnt + CNT_W'(1);
         if (iss_valid && !iss_ready) perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Directed bench for riscv_pipe_ctrl at NUM_STAGES=10, RESULT_STAGE=6, FLUSH_DEPTH=3.
module tb_riscv_pipe_ctrl;
   localparam int N = 10;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         iss_valid, iss_ready, iss_we;
   logic [4:0]   iss_rd, iss_rs1, iss_rs2;
   logic         iss_rs1_used, iss_rs2_used;
   logic         stall_in, flush_in;
   logic [N-1:0] stage_valid;
   logic         com_valid, com_we;
   logic [4:0]   com_rd;
   logic         fwd_rs1_hit, fwd_rs2_hit;
   logic [3:0]   fwd_rs1_stage, fwd_rs2_stage;
   logic [31:0]  perf_commit_cnt, perf_stall_cnt;

   int checks = 0;
   int failures = 0;
   int exp_commit = 0;
   int exp_stall = 0;
   int n;

   always #5 clk = ~clk;

   riscv_pipe_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_rd(iss_rd), .iss_we(iss_we),
      .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
      .iss_rs1_used(iss_rs1_used), .iss_rs2_used(iss_rs2_used),
      .stall_in(stall_in), .flush_in(flush_in),
      .stage_valid(stage_valid),
      .com_valid(com_valid), .com_rd(com_rd), .com_we(com_we),
      .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
      .fwd_rs1_stage(fwd_rs1_stage), .fwd_rs2_stage(fwd_rs2_stage),
      .perf_commit_cnt(perf_commit_cnt), .perf_stall_cnt(perf_stall_cnt)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_one(input logic [4:0] rd);
      iss_valid = 1'b1; iss_rd = rd; iss_we = 1'b1;
      iss_rs1_used = 1'b0; iss_rs2_used = 1'b0;
      tick();
      iss_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd5; iss_we = 1'b1;
      iss_rs1 = '0; iss_rs2 = '0; iss_rs1_used = 1'b0; iss_rs2_used = 1'b0;

      // Reset held for two edges with traffic offered.
      tick(); tick();
      check("rst_stage_valid", stage_valid, 0);
      check("rst_com_valid", com_valid, 0);
      check("rst_commit_cnt", perf_commit_cnt, 0);
      check("rst_stall_cnt", perf_stall_cnt, 0);
      check("rst_iss_ready", iss_ready, 1);
      check("rst_fwd_hit", {fwd_rs1_hit, fwd_rs2_hit}, 0);
      check("rst_fwd_stage", {fwd_rs1_stage, fwd_rs2_stage}, 0);
      rst_n = 1'b1; iss_valid = 1'b0;

      // Single issue: accepted at edge 0, commit strobe in the cycle before edge 10.
      iss_valid = 1'b1; iss_rd = 5'd5; iss_we = 1'b1;
      #1 check("single_ready", iss_ready, 1);
      tick();
      iss_valid = 1'b0;
      check("single_stage0", stage_valid, 10'h001);
      repeat (8) tick();
      check("single_no_early_commit", com_valid, 0);
      tick();
      check("single_com_valid", com_valid, 1);
      check("single_com_rd", com_rd, 5);
      check("single_com_we", com_we, 1);
      tick();
      check("single_after_commit", {com_valid, stage_valid}, 0);
      check("single_commit_cnt", perf_commit_cnt, 1);
      exp_commit = 1;

      // RAW on rs1 against rd=5.
      iss_valid = 1'b1; iss_rd = 5'd5; iss_we = 1'b1;
      tick();
      iss_rd = 5'd7; iss_rs1 = 5'd5; iss_rs1_used = 1'b1;
      #1;
      n = 0;
      while (!iss_ready && n < 40) begin
         tick();
         n++;
      end
`ifdef RISCV_PIPE_FWD_EN
      exp_stall = 6;
      check("raw_stall_cycles", n, 6);
      check("raw_fwd_hit", fwd_rs1_hit, 1);
      check("raw_fwd_stage", fwd_rs1_stage, 6);
`else
      exp_stall = 10;
      check("raw_stall_cycles", n, 10);
      check("raw_fwd_hit", fwd_rs1_hit, 0);
`endif
      check("raw_stall_cnt", perf_stall_cnt, exp_stall);
      tick();
      iss_valid = 1'b0; iss_rs1_used = 1'b0;
`ifdef RISCV_PIPE_FWD_EN
      check("raw_accept_stages", stage_valid, 10'h081);
`else
      check("raw_accept_stages", stage_valid, 10'h001);
`endif
      repeat (N + 1) tick();
      exp_commit += 2;
      check("raw_commit_cnt", perf_commit_cnt, exp_commit);

      // Producer writing x0 never interlocks.
      iss_valid = 1'b1; iss_rd = 5'd0; iss_we = 1'b1;
      tick();
      iss_rd = 5'd8; iss_rs1 = 5'd0; iss_rs1_used = 1'b1;
      #1 check("x0_no_hazard", iss_ready, 1);
      tick();
      iss_valid = 1'b0; iss_rs1_used = 1'b0;
      check("x0_stall_cnt", perf_stall_cnt, exp_stall);
      exp_commit += 2;

      // rs2 hazard against stage 0; readiness ignores iss_valid and the used flag gates it.
      issue_one(5'd9);
      iss_rs2 = 5'd9; iss_rs2_used = 1'b1;
      #1 check("rs2_hazard", iss_ready, 0);
      check("rs2_young_no_fwd", fwd_rs2_hit, 0);
      iss_rs2_used = 1'b0;
      #1 check("rs2_unused", iss_ready, 1);
      exp_commit += 1;
      repeat (N + 1) tick();
      check("rs2_commit_cnt", perf_commit_cnt, exp_commit);

      // Flush with stages 0..4 occupied.
      for (int i = 0; i < 5; i++) issue_one(5'(10 + i));
      check("flush_pre", stage_valid, 10'h01F);
      flush_in = 1'b1; iss_valid = 1'b1; iss_rd = 5'd15;
      #1 check("flush_ready", iss_ready, 0);
      tick();
      flush_in = 1'b0; iss_valid = 1'b0;
      exp_stall++;
      check("flush_post", stage_valid, 10'h030);
      check("flush_stall_cnt", perf_stall_cnt, exp_stall);
      repeat (4) tick();
      check("flush_survivor_commit", {com_valid, com_rd}, {1'b1, 5'd10});
      exp_commit += 2;
      repeat (N + 1) tick();
      check("flush_commit_cnt", perf_commit_cnt, exp_commit);

      // Stall with an instruction sitting in the commit stage; flush on the third stall cycle.
      issue_one(5'd3);
      repeat (5) tick();
      for (int i = 0; i < 4; i++) issue_one(5'(20 + i));
      check("stall_pre", stage_valid, 10'h20F);
      stall_in = 1'b1; iss_valid = 1'b1; iss_rd = 5'd24;
      for (int i = 0; i < 4; i++) begin
         flush_in = (i == 2);
         #1;
         check("stall_com_valid", com_valid, 0);
         check("stall_iss_ready", iss_ready, 0);
         tick();
      end
      flush_in = 1'b0;
      exp_stall += 4;
      check("stall_flush_stages", stage_valid, 10'h208);
      check("stall_no_commit", perf_commit_cnt, exp_commit);
      check("stall_stall_cnt", perf_stall_cnt, exp_stall);
      stall_in = 1'b0; iss_valid = 1'b0;
      #1 check("stall_release_commit", {com_valid, com_rd}, {1'b1, 5'd3});
      tick();
      exp_commit++;
      check("stall_single_commit", perf_commit_cnt, exp_commit);
      check("stall_after", {com_valid, stage_valid}, {1'b0, 10'h010});

      // Reset mid-operation discards in-flight work.
      rst_n = 1'b0;
      tick();
      check("midrst_stages", stage_valid, 0);
      check("midrst_counters", {perf_commit_cnt, perf_stall_cnt}, 0);
      rst_n = 1'b1;
      repeat (N + 1) begin
         check("midrst_no_commit", com_valid, 0);
         tick();
      end
      check("midrst_commit_cnt", perf_commit_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/riscv_pipe_ctrl.md
Name: riscv_pipe_ctrl

Overview:
- Parametrised pipeline control and hazard unit for the in-order RISC-V core. Generalises the fixed 10-stage valid chain to NUM_STAGES stages.
- Tracks per-stage valid/rd/we, enforces RAW hazards at issue, and handles global stall (backpressure) and partial flush (redirect).
- Produces commit strobes and performance counters.
- Sits between ID (issue) and the execute/memory datapath; the datapath stages consume its stage-valid vector.

Parameters:
- NUM_STAGES, 10, tracked stages after issue (stage 0 youngest, NUM_STAGES-1 = commit); legal 2..32.
- RESULT_STAGE, 6, first stage index whose result is forwardable; 1..NUM_STAGES-1.
- FLUSH_DEPTH, 3, stages 0..FLUSH_DEPTH-1 killed by flush; 1..NUM_STAGES.
- REG_AW, 5, register address width.
- CNT_W, 32, performance counter width.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset: synchronous, active-low.
- iss_valid, in, 1, instruction offered at issue.
- iss_ready, out, 1, issue accepted this edge when iss_valid&&iss_ready.
- iss_rd, in, REG_AW, destination register.
- iss_we, in, 1, instruction writes rd.
- iss_rs1 / iss_rs2, in, REG_AW, source registers.
- iss_rs1_used / iss_rs2_used, in, 1, source is read.
- stall_in, in, 1, global backpressure; whole pipe holds.
- flush_in, in, 1, kill young stages.
- stage_valid, out, NUM_STAGES, per-stage valid vector.
- com_valid, out, 1, instruction leaves last stage this edge.
- com_rd, out, REG_AW, rd of committing instruction.
- com_we, out, 1, committing instruction writes rd.
- fwd_rs1_hit / fwd_rs2_hit, out, 1, operand sourced by forwarding (macro only, else 0).
- fwd_rs1_stage / fwd_rs2_stage, out, $clog2(NUM_STAGES), producer stage index.
- perf_commit_cnt, out, CNT_W, committed instructions.
- perf_stall_cnt, out, CNT_W, cycles with iss_valid && !iss_ready.

Behaviour:
- Reset (rst_n low at an edge): all stage valids=0, counters=0. Outputs after reset: com_valid=0, stage_valid=0, fwd_*_hit=0, fwd_*_stage=0, iss_ready=1 (when stall_in=0, flush_in=0). Per-stage rd/we fields are not reset and are always qualified by valid.
- Advance (stall_in=0): stage k+1 <= stage k; stage 0 <= issued instruction, else a bubble.
- Hold (stall_in=1): all stages keep their contents; no issue.
- Commit: com_valid = valid[NUM_STAGES-1] && !stall_in; com_rd/com_we come from the last stage. No duplicate commit across a stall.
- Latency: an instruction accepted at edge n commits at edge n+NUM_STAGES when there are no stalls (com_valid high during the preceding cycle).
- Hazard (rs_used, rs!=0): a match is any valid stage with we=1 and rd==rs, all stages 0..NUM_STAGES-1 included.
  - Without macro: any match stalls issue.
  - rd=x0 never creates a hazard.
- iss_ready = !stall_in && !flush_in && !hazard. It does not depend on iss_valid.
- Flush: stages 0..FLUSH_DEPTH-1 are cleared at the edge. Older stages advance, or hold if stall_in=1. Flush has priority over stall for the killed stages. The issue slot is dropped.
- Counters increment by 1 per event and wrap from all-ones to 0. They are not cleared by flush.
- Reset asserted mid-operation discards all in-flight instructions with no commit strobe.

Optional Feature:
- Macro RISCV_PIPE_FWD_EN.
- When defined, for each operand the youngest matching producer decides the result:
  - Producer stage < RESULT_STAGE: stall.
  - Otherwise: no stall from that operand; fwd_rsX_hit=1 and fwd_rsX_stage = that stage index.
- When undefined, fwd_* outputs are tied to 0 and the plain stall rule applies.

Test Plan (NUM_STAGES=10, RESULT_STAGE=6, FLUSH_DEPTH=3):
- Reset: hold rst_n=0 for 2 edges with traffic -> stage_valid=0, com_valid=0, counters=0, iss_ready=1.
- Single issue: rd=5, we=1 accepted at edge 0 -> com_valid=1 with com_rd=5 before edge 10; perf_commit_cnt=1.
- RAW, no macro: producer rd=5 at edge 0, consumer rs1=5 offered from cycle 1 -> iss_ready=0 for 10 cycles, accepted at edge 11, perf_stall_cnt=10. Same test with rd=0 -> no stall.
- RAW, with macro: same stimulus -> 6 stall cycles, then fwd_rs1_hit=1 with fwd_rs1_stage=6, accepted at edge 7, perf_stall_cnt=6.
- Flush: stages 0..4 valid, flush_in=1 with iss_valid=1 -> after edge, only stages 4 and 5 valid; issue dropped.
- Stall at commit: instruction in stage 9, stall_in=1 for 4 cycles -> com_valid=0 throughout, then exactly one commit; flush during stall clears stages 0..2 only.
